mac_result_collector: RTL
=========================

MAC_RESULT_COLLECTOR -- requirements
Module: mac_result_collector

Interface
REQ-001 The block SHALL have one clock, `clk`, and an asynchronous active-low reset, `rst_n`; all other state SHALL be updated on the rising edge of `clk`.
REQ-002 Parameter LATENCY, default 4: rising edges from operand sample to a valid `mac_out` in the upstream multiply-add stage (a*b*c+d).
REQ-003 Parameter DEPTH, default 4 (power of two, 2..16): number of result FIFO entries.
REQ-004 Port `clk`, input, 1 bit: clock.
REQ-005 Port `rst_n`, input, 1 bit: asynchronous active-low reset.
REQ-006 Port `issue`, input, 1 bit: a new operand set (a, b, c, d) is presented to the upstream stage this cycle.
REQ-007 Port `mac_out`, input, 16 bits: result register of the upstream stage.
REQ-008 Port `clr`, input, 1 bit: synchronous flush of all state.
REQ-009 Port `res_data`, output, 16 bits: FIFO head entry.
REQ-010 Port `res_valid`, output, 1 bit: the FIFO is non-empty.
REQ-011 Port `res_ready`, input, 1 bit: consumer accepts the head entry.
REQ-012 Port `level`, output, 5 bits: current FIFO occupancy.
REQ-013 Port `overflow`, output, 1 bit: sticky flag, a result was dropped.
REQ-014 Port `drop_cnt`, output, 8 bits: saturating count of dropped results.
REQ-015 Port `sum`, output, 24 bits: wrapping sum of all captured results.

Function
REQ-016 Alignment: `issue` SHALL feed a LATENCY-deep shift register; its last tap (`cap`) SHALL be high exactly LATENCY rising edges after the edge that sampled `issue`=1.
REQ-017 Capture: when `cap`=1, the block SHALL sample `mac_out` on that edge as the result for the matching issue.
REQ-018 Back-to-back `issue` on consecutive cycles SHALL produce consecutive captures, one per cycle, with no loss while the FIFO has room.
REQ-019 FIFO transfer: a pop SHALL occur when `res_valid`=1 and `res_ready`=1.
REQ-020 The FIFO SHALL be first-word-fall-through: `res_data` SHALL equal the oldest entry whenever `res_valid`=1; it is don't-care when empty.
REQ-021 Push with the FIFO not full: write the result and increment `level`.
REQ-022 Push and pop on the same edge, at any level including full: both SHALL occur, `level` SHALL be unchanged, and nothing SHALL be dropped.
REQ-023 Push while full with no pop: the result SHALL be discarded and `overflow` set to 1.
REQ-024 On such a discard, `drop_cnt` SHALL increment and saturate at 255.
REQ-025 Pop while empty SHALL be ignored: no pointer movement, `level` stays 0.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 `level` SHALL range 0..DEPTH.
REQ-028 `sum` SHALL add every captured (not dropped) result, zero-extended, modulo 2^24.
REQ-029 `clr`=1 SHALL, on that edge, empty the FIFO, zero the shift register, `level`, `overflow`, `drop_cnt` and `sum`.
REQ-030 Under `clr`=1, a simultaneous capture, push or pop SHALL be discarded.
REQ-031 `res_valid`, `level` and `overflow` SHALL be registered outputs, with no combinational path from `res_ready`.

Reset
REQ-032 `rst_n`=0 SHALL immediately, without a clock, clear the shift register and FIFO pointers, and force `res_valid`=0, `level`=0, `overflow`=0, `drop_cnt`=0 and `sum`=0.
REQ-033 FIFO storage need not be reset.
REQ-034 Assertion of `rst_n` mid-operation SHALL lose all in-flight issues; no capture SHALL occur for issues sampled before reset release.
REQ-035 After `rst_n` release, the first capture SHALL occur no earlier than LATENCY edges after the first sampled `issue`.

Verification
REQ-036 Single issue, operands (1,2,3,4), upstream result 10, res_ready=1 -> `res_valid` rises one cycle after the capture edge with `res_data`=10; `sum`=10.
REQ-037 Three issues 8 cycles apart, operands (1,2,3,4), (2,3,4,5), (3,4,5,6), res_ready=0 -> FIFO holds 10, 29, 66 in order; `level`=3; `sum`=105.
REQ-038 Six consecutive issues, res_ready=0, DEPTH=4 -> `level`=4, `overflow`=1, `drop_cnt`=2; subsequent pops return the first four results in order.
REQ-039 FIFO full with res_ready=1 held while captures continue every cycle -> one push and one pop per edge, `level` stays 4, `drop_cnt` unchanged.
REQ-040 Issue, then `rst_n` pulsed low 2 cycles after the issue -> outputs zero immediately; no `res_valid` within 10 cycles after release.
REQ-041 260 drops with no pops -> `drop_cnt`=255 and holds; `clr` pulse -> all counters and flags are 0 and `res_valid`=0 on the next cycle.

Source files
------------

// File: rtl/mac_result_collector.sv
// Collects results from a fixed-latency multiply-add stage and buffers them in
// a first-word-fall-through FIFO with drop accounting and a running sum.
module mac_result_collector #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue,
   input  logic [15:0] mac_out,
   input  logic        clr,
   output logic [15:0] res_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [4:0]  level,
   output logic        overflow,
   output logic [7:0]  drop_cnt,
   output logic [23:0] sum
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LW = 5;
   localparam int unsigned DW = 16;
   localparam int unsigned SW = 24;
   localparam int unsigned CW = 8;

   logic [LATENCY-1:0] align;
   logic [LATENCY-1:0] align_nxt;
   logic [DW-1:0]      mem [DEPTH];
   logic [AW-1:0]      wptr;
   logic [AW-1:0]      rptr;
   logic [LW-1:0]      level_nxt;
   logic               cap;
   logic               full;
   logic               pop;
   logic               push;
   logic               drop;

   // Last alignment tap marks the cycle whose edge samples the matching result.
   assign cap  = align[LATENCY-1];
   assign full = (level == LW'(DEPTH));
   // Pop only on a registered valid; a pop while empty is ignored.
   assign pop  = res_valid & res_ready & ~clr;
   // A pop frees a slot on the same edge, so full+pop still accepts the push.
   assign push = cap & ~clr & (~full | pop);
   assign drop = cap & ~clr & full & ~pop;

   assign res_data = mem[rptr];

   // Next alignment vector and next occupancy.
   always_comb begin
      align_nxt = LATENCY'({align, issue});
      level_nxt = level;
      case ({push, pop})
         2'b10:   level_nxt = level + LW'(1);
         2'b01:   level_nxt = level - LW'(1);
         default: level_nxt = level;
      endcase
   end

   // Issue alignment shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         align <= '0;
      end else if (clr) begin
         align <= '0;
      end else begin
         align <= align_nxt;
      end
   end

   // FIFO storage, not reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= mac_out;
      end
   end

   // FIFO pointers, occupancy and valid flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         res_valid <= 1'b0;
      end else if (clr) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         res_valid <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         level     <= level_nxt;
         res_valid <= (level_nxt != '0);
      end
   end

   // Drop tracking and running sum of accepted results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         sum      <= '0;
      end else if (clr) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
         sum      <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {CW{1'b1}}) begin
               drop_cnt <= drop_cnt + CW'(1);
            end
         end
         if (push) begin
            sum <= sum + SW'(mac_out);
         end
      end
   end

endmodule
